// File: rtl/fancy_counter_gen_if.sv
// Handshake/bus bundle for fancy_counter_gen: control inputs toward the counter,
// count, fancy value and terminal-count pulse back to the user.
interface fancy_counter_gen_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] fancy_data;
  logic             tc;

  modport master (
    output en, dir, load, load_value,
    input  data, fancy_data, tc
  );

  modport slave (
    input  en, dir, load, load_value,
    output data, fancy_data, tc
  );
endinterface

// File: rtl/fancy_counter_gen.sv
// Up/down counter with load, modulo or saturating limit, a DEPTH-stage history line
// and a derived fancy output. Define FANCY_COUNTER_GEN_OVERRIDE_EN to force fixed fancy values at counts 0/1/17.
module fancy_counter_gen #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 1,
  parameter int MODULO   = 0,
  parameter int SATURATE = 0
) (
  input  logic           clk,
  input  logic           reset,
  fancy_counter_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LIMIT = (MODULO == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] data_r;
  logic             tc_r;
  logic [WIDTH-1:0] hist_r [DEPTH];

  logic [WIDTH-1:0] data_nxt_s;
  logic             tc_nxt_s;
  logic             shift_s;
  logic [WIDTH-1:0] load_clamp_s;
  logic [WIDTH-1:0] delayed_s;
  logic [WIDTH-1:0] fancy_base_s;
  logic [WIDTH-1:0] fancy_s;

  // Next count and terminal-count decision; load beats a step.
  always_comb begin
    data_nxt_s   = data_r;
    tc_nxt_s     = 1'b0;
    shift_s      = 1'b0;
    load_clamp_s = (bus.load_value > LIMIT) ? LIMIT : bus.load_value;
    if (bus.load) begin
      data_nxt_s = load_clamp_s;
    end else if (bus.en) begin
      shift_s = 1'b1;
      if (!bus.dir) begin
        if (data_r == LIMIT) begin
          data_nxt_s = (SATURATE != 0) ? LIMIT : {WIDTH{1'b0}};
          tc_nxt_s   = 1'b1;
        end else begin
          data_nxt_s = data_r + ONE;
        end
      end else begin
        if (data_r == {WIDTH{1'b0}}) begin
          data_nxt_s = (SATURATE != 0) ? {WIDTH{1'b0}} : LIMIT;
          tc_nxt_s   = 1'b1;
        end else begin
          data_nxt_s = data_r - ONE;
        end
      end
    end else begin
      data_nxt_s = data_r;
    end
  end

  // Count, pulse and history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= {WIDTH{1'b0}};
      tc_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      data_r <= data_nxt_s;
      tc_r   <= tc_nxt_s;
      if (shift_s) begin
        hist_r[0] <= data_r;
        for (int i = 1; i < DEPTH; i++) begin
          hist_r[i] <= hist_r[i-1];
        end
      end
    end
  end

  assign delayed_s    = hist_r[DEPTH-1];
  assign fancy_base_s = (delayed_s ^ data_r) + data_r;

`ifdef FANCY_COUNTER_GEN_OVERRIDE_EN
  localparam logic [WIDTH-1:0] FANCY_AT_0  = WIDTH'(32'd17);
  localparam logic [WIDTH-1:0] FANCY_AT_1  = WIDTH'(32'd1287);
  localparam logic [WIDTH-1:0] FANCY_AT_17 = WIDTH'(32'd2137);
  localparam logic [WIDTH-1:0] COUNT_17    = WIDTH'(32'd17);

  // Fixed fancy values at three specific counts, base value elsewhere.
  always_comb begin
    if (data_r == {WIDTH{1'b0}}) begin
      fancy_s = FANCY_AT_0;
    end else if (data_r == ONE) begin
      fancy_s = FANCY_AT_1;
    end else if (data_r == COUNT_17) begin
      fancy_s = FANCY_AT_17;
    end else begin
      fancy_s = fancy_base_s;
    end
  end
`else
  assign fancy_s = fancy_base_s;
`endif

  assign bus.data       = data_r;
  assign bus.tc         = tc_r;
  assign bus.fancy_data = fancy_s;

endmodule

// File: tb/tb_fancy_counter_gen.sv
// Self-checking bench for fancy_counter_gen: four configurations driven by directed and
// random steps, expected values queued from a behavioural model and compared after each edge.
module tb_fancy_counter_gen;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   nvec  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  fancy_counter_gen_if #(.WIDTH(W)) b0 ();
  fancy_counter_gen_if #(.WIDTH(W)) b1 ();
  fancy_counter_gen_if #(.WIDTH(W)) b2 ();
  fancy_counter_gen_if #(.WIDTH(W)) b3 ();

  fancy_counter_gen #(.WIDTH(W)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  fancy_counter_gen #(.WIDTH(W), .MODULO(10)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  fancy_counter_gen #(.WIDTH(W), .SATURATE(1)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  fancy_counter_gen #(.WIDTH(W), .DEPTH(4)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));

  typedef struct {
    int         k;
    logic [W-1:0] d;
    logic [W-1:0] f;
    logic       t;
    string      tag;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] m_data [4];
  logic         m_tc   [4];
  logic [W-1:0] m_hist [4][4];

  function automatic logic [W-1:0] lim_of(int k);
    return (k == 1) ? 16'd9 : 16'hFFFF;
  endfunction

  function automatic logic sat_of(int k);
    return (k == 2);
  endfunction

  function automatic int dep_of(int k);
    return (k == 3) ? 4 : 1;
  endfunction

  function automatic logic [W-1:0] fancy_of(logic [W-1:0] d, logic [W-1:0] dl);
`ifdef FANCY_COUNTER_GEN_OVERRIDE_EN
    if (d == 16'd0)  return 16'd17;
    if (d == 16'd1)  return 16'd1287;
    if (d == 16'd17) return 16'd2137;
`endif
    return (dl ^ d) + d;
  endfunction

  function automatic logic [W-1:0] dut_data(int k);
    case (k)
      0: return b0.data;
      1: return b1.data;
      2: return b2.data;
      default: return b3.data;
    endcase
  endfunction

  function automatic logic [W-1:0] dut_fancy(int k);
    case (k)
      0: return b0.fancy_data;
      1: return b1.fancy_data;
      2: return b2.fancy_data;
      default: return b3.fancy_data;
    endcase
  endfunction

  function automatic logic dut_tc(int k);
    case (k)
      0: return b0.tc;
      1: return b1.tc;
      2: return b2.tc;
      default: return b3.tc;
    endcase
  endfunction

  task automatic model_step(input int k, input logic rs, input logic ld,
                            input logic [W-1:0] lv, input logic e, input logic dr);
    logic [W-1:0] lim;
    lim = lim_of(k);
    if (rs) begin
      m_data[k] = 16'd0;
      m_tc[k]   = 1'b0;
      for (int i = 0; i < 4; i++) m_hist[k][i] = 16'd0;
    end else if (ld) begin
      m_data[k] = (lv > lim) ? lim : lv;
      m_tc[k]   = 1'b0;
    end else if (e) begin
      for (int i = 3; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
      m_hist[k][0] = m_data[k];
      m_tc[k] = 1'b0;
      if (!dr) begin
        if (m_data[k] == lim) begin
          m_data[k] = sat_of(k) ? lim : 16'd0;
          m_tc[k]   = 1'b1;
        end else begin
          m_data[k] = m_data[k] + 16'd1;
        end
      end else begin
        if (m_data[k] == 16'd0) begin
          m_data[k] = sat_of(k) ? 16'd0 : lim;
          m_tc[k]   = 1'b1;
        end else begin
          m_data[k] = m_data[k] - 16'd1;
        end
      end
    end else begin
      m_tc[k] = 1'b0;
    end
  endtask

  task automatic set_in(input int k, input logic ld, input logic [W-1:0] lv,
                        input logic e, input logic dr);
    b0.load = 1'b0; b0.load_value = 16'd0; b0.en = 1'b0; b0.dir = 1'b0;
    b1.load = 1'b0; b1.load_value = 16'd0; b1.en = 1'b0; b1.dir = 1'b0;
    b2.load = 1'b0; b2.load_value = 16'd0; b2.en = 1'b0; b2.dir = 1'b0;
    b3.load = 1'b0; b3.load_value = 16'd0; b3.en = 1'b0; b3.dir = 1'b0;
    case (k)
      0: begin b0.load = ld; b0.load_value = lv; b0.en = e; b0.dir = dr; end
      1: begin b1.load = ld; b1.load_value = lv; b1.en = e; b1.dir = dr; end
      2: begin b2.load = ld; b2.load_value = lv; b2.en = e; b2.dir = dr; end
      3: begin b3.load = ld; b3.load_value = lv; b3.en = e; b3.dir = dr; end
      default: ;
    endcase
  endtask

  // One clock step: drive unit k (others idle), queue expectations for all units, compare after the edge.
  task automatic step(input int k, input logic rs, input logic ld, input logic [W-1:0] lv,
                      input logic e, input logic dr, input string tag);
    exp_t ex;
    reset = rs;
    set_in(k, ld, lv, e, dr);
    for (int j = 0; j < 4; j++) begin
      if (j == k) model_step(j, rs, ld, lv, e, dr);
      else        model_step(j, rs, 1'b0, 16'd0, 1'b0, 1'b0);
      ex.k   = j;
      ex.d   = m_data[j];
      ex.f   = fancy_of(m_data[j], m_hist[j][dep_of(j)-1]);
      ex.t   = m_tc[j];
      ex.tag = tag;
      sbq.push_back(ex);
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      ex = sbq.pop_front();
      nvec++;
      assert (dut_data(ex.k) === ex.d) else begin
        nfail++;
        $error("FAIL %s u%0d data: got %0d want %0d", ex.tag, ex.k, dut_data(ex.k), ex.d);
      end
      nvec++;
      assert (dut_fancy(ex.k) === ex.f) else begin
        nfail++;
        $error("FAIL %s u%0d fancy_data: got %0d want %0d", ex.tag, ex.k, dut_fancy(ex.k), ex.f);
      end
      nvec++;
      assert (dut_tc(ex.k) === ex.t) else begin
        nfail++;
        $error("FAIL %s u%0d tc: got %0b want %0b", ex.tag, ex.k, dut_tc(ex.k), ex.t);
      end
    end
  endtask

  initial begin
    logic         r_ld, r_en, r_dir, r_rs;
    logic [W-1:0] r_lv;
    reset = 1'b1;
    set_in(-1, 1'b0, 16'd0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) step(-1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 20; i++) step(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, "t1_up");
    for (int i = 0; i < 2; i++) step(0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, "t1_hold");
    step(0, 1'b0, 1'b1, 16'd3, 1'b1, 1'b1, "ld_over_en");

    for (int i = 0; i < 400; i++) begin
      r_rs  = (i >= 200) && (i < 203);
      r_ld  = ($urandom_range(0, 99) < 8);
      r_lv  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      r_en  = ($urandom_range(0, 3) != 0);
      r_dir = 1'($urandom_range(0, 1));
      step(i % 4, r_rs, r_ld, r_lv, r_en, r_dir, "t2_rand");
    end

    step(0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, "t2_ld_max");
    step(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, "t2_wrap_up");
    step(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, "t2_wrap_dn");

    step(1, 1'b0, 1'b1, 16'd7, 1'b0, 1'b0, "t3_ld7");
    for (int i = 0; i < 4; i++) step(1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, "t3_mod_up");
    for (int i = 0; i < 2; i++) step(1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, "t3_mod_dn");
    step(1, 1'b0, 1'b1, 16'd12, 1'b0, 1'b0, "t5_ld_clamp");

    step(2, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, "t4_ld_max");
    for (int i = 0; i < 3; i++) step(2, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, "t4_sat_up");
    step(2, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, "t4_sat_dn");
    step(2, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, "t4_ld0");
    for (int i = 0; i < 2; i++) step(2, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, "t4_sat_lo");

    step(-1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "t5_reset");
    for (int i = 0; i < 6; i++) step(3, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, "t5_depth4");
    step(3, 1'b0, 1'b1, 16'd100, 1'b1, 1'b0, "t5_ld100");
    for (int i = 0; i < 2; i++) step(3, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, "t5_after_ld");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
